write_back: RTL and testbench
=============================

Name: write_back

Overview:
- Final pipeline stage; consumer end of the execute-to-write interface.
- Accepts one completed operation per handshake and commits it.
- Commit targets: register-file write port, flags write port, or a single-beat memory store with wait-request.
- Stalls the execute stage via hold while a two-cycle upper-value commit or a waited store is in progress.

Parameters:
- WAIT_LIMIT, 15, maximum cycles a store may sit in wait-request before it is abandoned with bus_error.
- REG_BITS, 5, register index width.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- registers  in  regfile_t  current register file contents; used to read the store base address.
- in_is_valid  in  1  upstream flow valid.
- in_hold  out  1  upstream flow hold (combinational).
- pc  in  32  pc of the incoming operation; reported only, on commit_pc.
- destination_register  in  REG_BITS  register to write, or store address register; 0 means none.
- is_writing_memory  in  1  operation is a store.
- flags  in  4  {carry, negative, overflow, zero}.
- destination_value  in  32  register result, or store data.
- has_upper_value  in  1  upper_value must also be committed.
- upper_value  in  32  high product word, or remainder.
- adjustment_value  in  32  store address offset.
- has_flushed  in  1  operation was squashed; commit nothing.
- rf_write_enable  out  1  register write strobe.
- rf_write_register  out  REG_BITS  register write index.
- rf_write_value  out  32  register write data.
- flags_write_enable  out  1  flags write strobe.
- flags_value  out  4  flags write data.
- mem_write  out  1  store request.
- mem_address  out  32  store address.
- mem_write_data  out  32  store data.
- mem_wait_request  in  1  memory not ready; request must be held.
- bus_error  out  1  one-cycle pulse when a store is abandoned.
- commit_valid  out  1  one-cycle pulse when an operation retires.
- commit_pc  out  32  pc of the retired operation.

Behaviour:
- Reset: state=IDLE; all outputs 0, including in_hold, strobes, address/data, bus_error, commit_valid, commit_pc; wait counter 0.
- Accept: occurs when state==IDLE and in_is_valid. All inputs are captured that edge. Every output is registered, so commit activity appears the cycle after acceptance.
- Acceptance with has_flushed=1: no writes and no commit_valid; stays IDLE.
- Normal register op (is_writing_memory=0):
  - next cycle: rf_write_enable=(destination_register!=0), value=destination_value;
  - flags_write_enable=1 with flags_value=flags (flags are written even when destination is 0);
  - if has_upper_value=0: commit_valid=1, back to IDLE.
- UPPER state (entered when has_upper_value=1): in the following cycle, rf_write_register=destination_register+1 (mod 32) and rf_write_value=upper_value.
  - Register 0 is never written: if destination_register is 0 or 31, the upper write is suppressed.
  - commit_valid is raised then, and the state returns to IDLE. Flags are written only in the first cycle.
- Store (is_writing_memory=1):
  - destination_register==0 (store suppressed upstream): no request, commit_valid=1 next cycle.
  - otherwise: STORE state; mem_address=registers[destination_register]+adjustment_value (32-bit wrap), mem_write_data=destination_value, mem_write=1.
  - Address and data are held stable while mem_wait_request=1.
  - Cycle with mem_write=1 and mem_wait_request=0: store complete; mem_write drops next cycle, commit_valid=1, IDLE.
  - Wait counter counts cycles with mem_wait_request=1. On reaching WAIT_LIMIT: mem_write drops, bus_error=1 for one cycle, commit_valid=1, IDLE.
  - has_upper_value is ignored for stores; no flags write.
- Hold:
  - in_hold=in_is_valid && (state!=IDLE || (state==IDLE && accepting an op that will enter UPPER or STORE)).
  - Since capture happens at acceptance, the hold to upstream is simply in_is_valid && state!=IDLE. The next op may be accepted in the same cycle the FSM returns to IDLE.
  - Back-to-back single-cycle ops are accepted every cycle.
- Strobes (rf_write_enable, flags_write_enable, commit_valid, bus_error) are one-cycle pulses.
- Reset mid-STORE or mid-UPPER: drop mem_write immediately, no commit, IDLE.

Decomposition:
- Shared package gets:
  - the write_back state enum {IDLE, UPPER, STORE};
  - a flag-index constant set (Carry=3, Negative=2, Overflow=1, Zero=0);
  - the existing regfile_t/regval_t and the Flags register index.
- No sub-module is needed. The store wait counter is small enough to inline.

Test Plan:
- Add result: dest=5, value=0x0000_0010, flags=4'b0001 -> next cycle rf_write_enable=1, reg 5 <= 0x10, flags_value=0001, commit_valid=1, in_hold=0 throughout.
- Multiply with upper: dest=6, value=0x1, upper=0xFFFF_FFFF -> reg 6 <= 0x1, then reg 7 <= 0xFFFF_FFFF; in_hold=1 for one cycle against the following valid op; dest=31 -> only reg 31 written.
- Store: registers[3]=0x1000, adjustment_value=0x8, data=0xDEAD_BEEF, wait_request high 3 cycles -> mem_address=0x1008 held 4 cycles, single commit, no bus_error.
- Store timeout: wait_request stuck high -> mem_write drops after 15 wait cycles, bus_error pulse, commit_valid pulse, next op accepted.
- has_flushed=1 with dest=5 and is_writing_memory=1 -> no rf/flags/mem activity, no commit_valid.
- Reset asserted during STORE wait -> mem_write=0 next cycle, all outputs 0, state IDLE.

Source files
------------

// File: rtl/write_back_pkg.sv
// Shared types for the write-back stage: register file shape, FSM states and flag bit positions.
package write_back_pkg;

    localparam int REG_COUNT = 32;

    typedef logic [31:0] regval_t;
    typedef regval_t [REG_COUNT-1:0] regfile_t;

    // Flags live outside the general register file, addressed one past its end.
    localparam int FLAGS_REGISTER = REG_COUNT;

    localparam int FLAG_CARRY    = 3;
    localparam int FLAG_NEGATIVE = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_ZERO     = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UPPER = 2'd1,
        STORE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/write_back.sv
// Final pipeline stage: commits one accepted operation to the register file, flags or memory.
// Every output is registered; commit activity appears the cycle after acceptance.
module write_back
    import write_back_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int REG_BITS   = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  regfile_t            registers,
    input  logic                in_is_valid,
    output logic                in_hold,
    input  logic [31:0]         pc,
    input  logic [REG_BITS-1:0] destination_register,
    input  logic                is_writing_memory,
    input  logic [3:0]          flags,
    input  logic [31:0]         destination_value,
    input  logic                has_upper_value,
    input  logic [31:0]         upper_value,
    input  logic [31:0]         adjustment_value,
    input  logic                has_flushed,
    output logic                rf_write_enable,
    output logic [REG_BITS-1:0] rf_write_register,
    output logic [31:0]         rf_write_value,
    output logic                flags_write_enable,
    output logic [3:0]          flags_value,
    output logic                mem_write,
    output logic [31:0]         mem_address,
    output logic [31:0]         mem_write_data,
    input  logic                mem_wait_request,
    output logic                bus_error,
    output logic                commit_valid,
    output logic [31:0]         commit_pc,
    output wb_state_t           debug_state
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    // Upstream handshake: an op transfers on a rising edge where in_is_valid=1 and
    // in_hold=0; upstream keeps the op stable while in_hold=1.
    wb_state_t           state, state_n;
    logic [CW-1:0]       wait_cnt, wait_n;
    logic [REG_BITS-1:0] upper_reg, upper_reg_n;
    logic [31:0]         upper_val, upper_val_n;
    logic                upper_en, upper_en_n;
    logic [31:0]         pc_q, pc_n;

    logic                rf_we_n, flags_we_n, mem_write_n, bus_error_n, commit_n;
    logic [REG_BITS-1:0] rf_reg_n;
    logic [31:0]         rf_val_n, mem_addr_n, mem_data_n, commit_pc_n;
    logic [3:0]          flags_val_n;

    assign in_hold     = in_is_valid && (state != IDLE);
    assign debug_state = state;

    always_comb begin
        state_n     = state;
        wait_n      = wait_cnt;
        upper_reg_n = upper_reg;
        upper_val_n = upper_val;
        upper_en_n  = upper_en;
        pc_n        = pc_q;
        rf_we_n     = 1'b0;
        rf_reg_n    = rf_write_register;
        rf_val_n    = rf_write_value;
        flags_we_n  = 1'b0;
        flags_val_n = flags_value;
        mem_write_n = mem_write;
        mem_addr_n  = mem_address;
        mem_data_n  = mem_write_data;
        bus_error_n = 1'b0;
        commit_n    = 1'b0;
        commit_pc_n = commit_pc;

        case (state)
            IDLE: begin
                if (in_is_valid && !has_flushed) begin
                    if (!is_writing_memory) begin
                        rf_we_n     = (destination_register != '0);
                        rf_reg_n    = destination_register;
                        rf_val_n    = destination_value;
                        flags_we_n  = 1'b1;
                        flags_val_n = flags;
                        if (has_upper_value) begin
                            state_n     = UPPER;
                            upper_reg_n = destination_register + 1'b1;
                            upper_val_n = upper_value;
                            // Register 0 must never be the upper target, from either side of the wrap.
                            upper_en_n  = (destination_register != '0) &&
                                          (destination_register != {REG_BITS{1'b1}});
                            pc_n        = pc;
                        end else begin
                            commit_n    = 1'b1;
                            commit_pc_n = pc;
                        end
                    end else if (destination_register == '0) begin
                        commit_n    = 1'b1;
                        commit_pc_n = pc;
                    end else begin
                        state_n     = STORE;
                        mem_write_n = 1'b1;
                        mem_addr_n  = registers[destination_register] + adjustment_value;
                        mem_data_n  = destination_value;
                        wait_n      = '0;
                        pc_n        = pc;
                    end
                end
            end
            UPPER: begin
                rf_we_n     = upper_en;
                rf_reg_n    = upper_reg;
                rf_val_n    = upper_val;
                commit_n    = 1'b1;
                commit_pc_n = pc_q;
                state_n     = IDLE;
            end
            STORE: begin
                if (!mem_wait_request) begin
                    mem_write_n = 1'b0;
                    commit_n    = 1'b1;
                    commit_pc_n = pc_q;
                    state_n     = IDLE;
                end else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                    mem_write_n = 1'b0;
                    bus_error_n = 1'b1;
                    commit_n    = 1'b1;
                    commit_pc_n = pc_q;
                    state_n     = IDLE;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            wait_cnt           <= '0;
            upper_reg          <= '0;
            upper_val          <= '0;
            upper_en           <= 1'b0;
            pc_q               <= '0;
            rf_write_enable    <= 1'b0;
            rf_write_register  <= '0;
            rf_write_value     <= '0;
            flags_write_enable <= 1'b0;
            flags_value        <= '0;
            mem_write          <= 1'b0;
            mem_address        <= '0;
            mem_write_data     <= '0;
            bus_error          <= 1'b0;
            commit_valid       <= 1'b0;
            commit_pc          <= '0;
        end else begin
            state              <= state_n;
            wait_cnt           <= wait_n;
            upper_reg          <= upper_reg_n;
            upper_val          <= upper_val_n;
            upper_en           <= upper_en_n;
            pc_q               <= pc_n;
            rf_write_enable    <= rf_we_n;
            rf_write_register  <= rf_reg_n;
            rf_write_value     <= rf_val_n;
            flags_write_enable <= flags_we_n;
            flags_value        <= flags_val_n;
            mem_write          <= mem_write_n;
            mem_address        <= mem_addr_n;
            mem_write_data     <= mem_data_n;
            bus_error          <= bus_error_n;
            commit_valid       <= commit_n;
            commit_pc          <= commit_pc_n;
        end
    end

endmodule

// File: tb/tb_write_back.sv
// Randomized bench for write_back: a transaction-level model predicts each retirement
// (cycle stamp, register/flag writes, store window, hold) from the accepted operation.
module tb_write_back;
    import write_back_pkg::*;

    localparam int WAIT_LIMIT = 15;
    localparam logic [63:0] NONE = '1;

    logic clock = 1'b0;
    logic reset;
    regfile_t registers;
    logic in_is_valid, in_hold;
    logic [31:0] pc;
    logic [4:0] destination_register;
    logic is_writing_memory;
    logic [3:0] flags;
    logic [31:0] destination_value;
    logic has_upper_value;
    logic [31:0] upper_value, adjustment_value;
    logic has_flushed;
    logic rf_write_enable;
    logic [4:0] rf_write_register;
    logic [31:0] rf_write_value;
    logic flags_write_enable;
    logic [3:0] flags_value;
    logic mem_write;
    logic [31:0] mem_address, mem_write_data;
    logic mem_wait_request;
    logic bus_error, commit_valid;
    logic [31:0] commit_pc;
    wb_state_t debug_state;

    write_back #(.WAIT_LIMIT(WAIT_LIMIT), .REG_BITS(5)) dut (
        .clock(clock), .reset(reset), .registers(registers),
        .in_is_valid(in_is_valid), .in_hold(in_hold), .pc(pc),
        .destination_register(destination_register), .is_writing_memory(is_writing_memory),
        .flags(flags), .destination_value(destination_value),
        .has_upper_value(has_upper_value), .upper_value(upper_value),
        .adjustment_value(adjustment_value), .has_flushed(has_flushed),
        .rf_write_enable(rf_write_enable), .rf_write_register(rf_write_register),
        .rf_write_value(rf_write_value), .flags_write_enable(flags_write_enable),
        .flags_value(flags_value), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_wait_request(mem_wait_request),
        .bus_error(bus_error), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .debug_state(debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;
    logic [15:0] mc;
    assign mc = cyc[15:0];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    logic [63:0] rf_exp_q[$];
    logic [63:0] flags_exp_q[$];
    logic [63:0] commit_exp_q[$];
    logic [63:0] store_exp;
    int busy_until = -1;
    int store_lo = 0;
    int store_hi = -1;
    int cur_wait_n = 0;
    bit mon_en = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        bit          store;
        logic [3:0]  flags;
        logic [31:0] val;
        bit          upper;
        logic [31:0] upper_val;
        logic [31:0] adj;
        bit          flushed;
        int          wait_n;
    } op_t;

    // Reference model: what one accepted op must produce, stamped with the output cycle.
    task automatic model_accept(input op_t op, input int k);
        logic [31:0] addr;
        int d;
        if (op.flushed) return;
        if (!op.store) begin
            if (op.dest != 0) rf_exp_q.push_back({11'b0, 16'(k), op.dest, op.val});
            flags_exp_q.push_back({44'b0, 16'(k), op.flags});
            if (op.upper) begin
                if (op.dest != 0 && op.dest != 31)
                    rf_exp_q.push_back({11'b0, 16'(k + 1), 5'((op.dest + 1) % 32), op.upper_val});
                commit_exp_q.push_back({15'b0, 16'(k + 1), op.pc, 1'b0});
                busy_until = k;
            end else begin
                commit_exp_q.push_back({15'b0, 16'(k), op.pc, 1'b0});
            end
        end else if (op.dest == 0) begin
            commit_exp_q.push_back({15'b0, 16'(k), op.pc, 1'b0});
        end else begin
            addr = registers[op.dest] + op.adj;
            d = (op.wait_n < WAIT_LIMIT) ? op.wait_n + 1 : WAIT_LIMIT;
            commit_exp_q.push_back({15'b0, 16'(k + d), op.pc, op.wait_n >= WAIT_LIMIT});
            busy_until = k + d - 1;
            store_lo = k;
            store_hi = k + d - 1;
            store_exp = {addr, op.val};
            cur_wait_n = op.wait_n;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (mon_en) begin
            if (rf_write_enable)
                check("rf_write", {11'b0, mc, rf_write_register, rf_write_value},
                      rf_exp_q.size() > 0 ? rf_exp_q.pop_front() : NONE);
            if (flags_write_enable)
                check("flags_write", {44'b0, mc, flags_value},
                      flags_exp_q.size() > 0 ? flags_exp_q.pop_front() : NONE);
            if (commit_valid)
                check("commit", {15'b0, mc, commit_pc, bus_error},
                      commit_exp_q.size() > 0 ? commit_exp_q.pop_front() : NONE);
            if (bus_error) check("bus_error_with_commit", 64'(commit_valid), 64'd1);
            check("mem_write", 64'(mem_write), 64'(cyc >= store_lo && cyc <= store_hi));
            if (mem_write) check("store_addr_data", {mem_address, mem_write_data}, store_exp);
        end
    end

    // Memory side: hold wait_request for the chosen number of request cycles.
    int seen = 0;
    always @(negedge clock) begin
        if (mem_write) begin
            mem_wait_request = (seen < cur_wait_n);
            seen++;
        end else begin
            seen = 0;
            mem_wait_request = 1'($urandom);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic op_t blank_op();
        op_t o;
        o = '{pc: 0, dest: 0, store: 0, flags: 0, val: 0, upper: 0, upper_val: 0,
              adj: 0, flushed: 0, wait_n: 0};
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.pc        = $urandom;
        o.dest      = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31)
                                                  : 5'($urandom);
        o.store     = ($urandom_range(0, 2) == 0);
        o.flags     = 4'($urandom);
        o.val       = $urandom;
        o.upper     = ($urandom_range(0, 2) == 0);
        o.upper_val = $urandom;
        o.adj       = $urandom;
        o.flushed   = ($urandom_range(0, 7) == 0);
        o.wait_n    = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(0, 4);
        return o;
    endfunction

    task automatic drive_junk();
        in_is_valid          = 1'b0;
        pc                   = $urandom;
        destination_register = 5'($urandom);
        is_writing_memory    = 1'($urandom);
        flags                = 4'($urandom);
        destination_value    = $urandom;
        has_upper_value      = 1'($urandom);
        upper_value          = $urandom;
        adjustment_value     = $urandom;
        has_flushed          = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive_junk();
            @(negedge clock);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input op_t op);
        int polls;
        polls = 0;
        in_is_valid          = 1'b1;
        pc                   = op.pc;
        destination_register = op.dest;
        is_writing_memory    = op.store;
        flags                = op.flags;
        destination_value    = op.val;
        has_upper_value      = op.upper;
        upper_value          = op.upper_val;
        adjustment_value     = op.adj;
        has_flushed          = op.flushed;
        forever begin
            #1;
            check("in_hold", 64'(in_hold), 64'(cyc <= busy_until));
            if (!in_hold) begin
                model_accept(op, cyc + 1);
                break;
            end
            polls++;
            if (polls > 60) begin
                check("accept_timeout", 64'(in_hold), 64'd0);
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        drive_junk();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_we"}, 64'(rf_write_enable), 64'd0);
        check({tag, "_rf_reg_val"}, {27'b0, rf_write_register, rf_write_value}, 64'd0);
        check({tag, "_flags"}, {59'b0, flags_write_enable, flags_value}, 64'd0);
        check({tag, "_mem"}, {31'b0, mem_write, mem_address}, 64'd0);
        check({tag, "_mem_data"}, 64'(mem_write_data), 64'd0);
        check({tag, "_commit"}, {30'b0, bus_error, commit_valid, commit_pc}, 64'd0);
        check({tag, "_hold"}, 64'(in_hold), 64'd0);
        check({tag, "_state"}, 64'(debug_state), 64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        op_t o;
        registers = '0;
        for (int i = 0; i < 32; i++) registers[i] = $urandom;
        reset = 1'b1;
        drive_junk();
        mem_wait_request = 1'b0;
        repeat (3) @(negedge clock);
        in_is_valid = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;
        drive_junk();
        mon_en = 1;

        // Add result
        o = blank_op(); o.pc = 32'h100; o.dest = 5; o.val = 32'h10; o.flags = 4'b0001;
        send(o);
        idle(2);
        // Multiply with upper, followed immediately by another op that must see hold
        o = blank_op(); o.pc = 32'h104; o.dest = 6; o.val = 32'h1; o.upper = 1;
        o.upper_val = 32'hFFFF_FFFF; o.flags = 4'b0100;
        send(o);
        o = blank_op(); o.pc = 32'h108; o.dest = 9; o.val = 32'h55; o.flags = 4'b1000;
        send(o);
        idle(2);
        o = blank_op(); o.pc = 32'h10C; o.dest = 31; o.val = 32'h2; o.upper = 1;
        o.upper_val = 32'h1234_5678;
        send(o);
        o = blank_op(); o.pc = 32'h110; o.dest = 0; o.val = 32'h3; o.upper = 1;
        o.upper_val = 32'h9; o.flags = 4'b0010;
        send(o);
        idle(2);
        // Store with three wait cycles
        registers[3] = 32'h1000;
        o = blank_op(); o.pc = 32'h114; o.dest = 3; o.store = 1; o.adj = 32'h8;
        o.val = 32'hDEAD_BEEF; o.wait_n = 3;
        send(o);
        idle(6);
        // Store timeout, next op queued behind it
        o = blank_op(); o.pc = 32'h118; o.dest = 4; o.store = 1; o.adj = 32'hFFFF_FFF0;
        o.val = 32'hCAFE_F00D; o.wait_n = 40;
        send(o);
        o = blank_op(); o.pc = 32'h11C; o.dest = 2; o.val = 32'h77; o.flags = 4'b1111;
        send(o);
        idle(2);
        // Flushed store: nothing at all
        o = blank_op(); o.pc = 32'h120; o.dest = 5; o.store = 1; o.flushed = 1;
        send(o);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            o = rand_op();
            registers[o.dest] = $urandom;
            send(o);
            idle($urandom_range(0, 2));
        end

        // Reset in the middle of a waited store
        idle(25);
        check("drain_rf", 64'(rf_exp_q.size()), 64'd0);
        check("drain_commit", 64'(commit_exp_q.size()), 64'd0);
        o = blank_op(); o.pc = 32'h200; o.dest = 7; o.store = 1; o.adj = 32'h4;
        o.val = 32'h0BAD_CAFE; o.wait_n = 100;
        send(o);
        idle(3);
        mon_en = 0;
        reset = 1'b1;
        in_is_valid = 1'b1;
        @(negedge clock);
        #1;
        check_reset_outputs("mid_store_reset");
        check("pending_store_commit", 64'(commit_exp_q.size()), 64'd1);
        rf_exp_q.delete();
        flags_exp_q.delete();
        commit_exp_q.delete();
        busy_until = -1;
        store_hi = -1;
        cur_wait_n = 0;
        @(negedge clock);
        reset = 1'b0;
        drive_junk();
        mon_en = 1;

        for (int i = 0; i < 30; i++) begin
            o = rand_op();
            registers[o.dest] = $urandom;
            send(o);
            idle($urandom_range(0, 1));
        end
        idle(25);
        check("final_rf_q", 64'(rf_exp_q.size()), 64'd0);
        check("final_flags_q", 64'(flags_exp_q.size()), 64'd0);
        check("final_commit_q", 64'(commit_exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
